step_dir_gen: RTL and testbench

- Step/dir pulse generator for one motor axis; the transmit side of the step/dir interface.
- Host loads a signed step count and a step period through the 16-bit register bus, then pulses start.
- Block drives dir, then emits |count| step pulses at the programmed rate, with guaranteed pulse width, dir setup and dir hold.
- Exposes busy, done, aborted and remaining-step status to the host.

---
 rtl/step_dir_gen_if.sv | 25 ++
 rtl/step_dir_gen.sv | 200 ++++++++++++++++++++
 tb/tb_step_dir_gen.sv | 240 ++++++++++++++++++++++++
 3 files changed

// File: rtl/step_dir_gen_if.sv
// Host-side register bus, command strobes and status for one step/dir axis.
interface step_dir_gen_if;
    logic [1:0]  addr;
    logic [1:0]  be;
    logic [15:0] wrdata;
    logic        write;
    logic        start;
    logic        abort;
    logic        step;
    logic        dir;
    logic        busy;
    logic        done;
    logic        aborted;
    logic [31:0] remain;

    modport master (
        output addr, be, wrdata, write, start, abort,
        input  step, dir, busy, done, aborted, remain
    );

    modport slave (
        input  addr, be, wrdata, write, start, abort,
        output step, dir, busy, done, aborted, remain
    );
endinterface

// File: rtl/step_dir_gen.sv
// Step/dir pulse generator: emits |steps| pulses of PULSE_W cycles every
// max(period, 2*PULSE_W) cycles after a DIR_SETUP-cycle direction setup.
module step_dir_gen #(
    parameter int PULSE_W   = 8,
    parameter int DIR_SETUP = 8
) (
    input  logic           clk,
    input  logic           aclr,
    input  logic           sclr,
    step_dir_gen_if.slave  bus
);

    localparam logic [31:0] PMIN    = 32'(2 * PULSE_W);
    localparam logic [31:0] PW_LAST = 32'(PULSE_W - 1);
    localparam logic [31:0] SU_LAST = 32'(DIR_SETUP - 1);

    typedef enum logic [1:0] {IDLE, SETUP, HIGH, LOW} state_t;

    state_t             state_q, state_d;
    logic signed [31:0] steps_q, steps_d;
    logic [31:0]        period_q, period_d;
    logic [31:0]        per_q, per_d;
    logic [31:0]        cnt_q, cnt_d;
    logic [31:0]        remain_q, remain_d;
    logic               step_q, step_d;
    logic               dir_q, dir_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic               aborted_q, aborted_d;
    logic               abort_pend_q, abort_pend_d;

    function automatic logic [31:0] abs_u32(input logic signed [31:0] v);
        logic [31:0] u;
        u = v;
        return v[31] ? (~u + 32'd1) : u;
    endfunction

    function automatic logic [31:0] eff_period(input logic [31:0] p);
        return (p > PMIN) ? p : PMIN;
    endfunction

    function automatic logic [15:0] merge16(input logic [15:0] old_v,
                                            input logic [15:0] new_v,
                                            input logic [1:0]  be);
        logic [15:0] r;
        r = old_v;
        if (be[0]) r[7:0]  = new_v[7:0];
        if (be[1]) r[15:8] = new_v[15:8];
        return r;
    endfunction

    always_comb begin
        state_d      = state_q;
        steps_d      = steps_q;
        period_d     = period_q;
        per_d        = per_q;
        cnt_d        = cnt_q;
        remain_d     = remain_q;
        step_d       = step_q;
        dir_d        = dir_q;
        busy_d       = busy_q;
        done_d       = 1'b0;
        aborted_d    = aborted_q;
        abort_pend_d = abort_pend_q;

        // Registers are frozen for the duration of a move.
        if (bus.write && !busy_q) begin
            case (bus.addr)
                2'd0:    steps_d[15:0]   = merge16(steps_q[15:0],   bus.wrdata, bus.be);
                2'd1:    steps_d[31:16]  = merge16(steps_q[31:16],  bus.wrdata, bus.be);
                2'd2:    period_d[15:0]  = merge16(period_q[15:0],  bus.wrdata, bus.be);
                default: period_d[31:16] = merge16(period_q[31:16], bus.wrdata, bus.be);
            endcase
        end

        case (state_q)
            IDLE: begin
                if (bus.start && !bus.abort) begin
                    aborted_d    = 1'b0;
                    abort_pend_d = 1'b0;
                    if (steps_q == 32'sd0) begin
                        done_d = 1'b1;
                    end else begin
                        dir_d    = steps_q[31];
                        remain_d = abs_u32(steps_q);
                        per_d    = eff_period(period_q);
                        busy_d   = 1'b1;
                        cnt_d    = 32'd0;
                        state_d  = SETUP;
                    end
                end
            end
            SETUP: begin
                if (bus.abort) begin
                    busy_d    = 1'b0;
                    done_d    = 1'b1;
                    aborted_d = 1'b1;
                    state_d   = IDLE;
                end else if (cnt_q == SU_LAST) begin
                    step_d   = 1'b1;
                    remain_d = remain_q - 32'd1;
                    cnt_d    = 32'd0;
                    state_d  = HIGH;
                end else begin
                    cnt_d = cnt_q + 32'd1;
                end
            end
            HIGH: begin
                // An abort here is deferred so the pulse keeps its full width.
                cnt_d = cnt_q + 32'd1;
                if (cnt_q == PW_LAST) begin
                    step_d = 1'b0;
                    if (abort_pend_q || bus.abort) begin
                        busy_d       = 1'b0;
                        done_d       = 1'b1;
                        aborted_d    = 1'b1;
                        abort_pend_d = 1'b0;
                        state_d      = IDLE;
                    end else begin
                        state_d = LOW;
                    end
                end else begin
                    abort_pend_d = abort_pend_q | bus.abort;
                end
            end
            default: begin
                if (bus.abort) begin
                    busy_d    = 1'b0;
                    done_d    = 1'b1;
                    aborted_d = 1'b1;
                    state_d   = IDLE;
                end else if (cnt_q == per_q - 32'd1) begin
                    if (remain_q != 32'd0) begin
                        step_d   = 1'b1;
                        remain_d = remain_q - 32'd1;
                        cnt_d    = 32'd0;
                        state_d  = HIGH;
                    end else begin
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                        state_d = IDLE;
                    end
                end else begin
                    cnt_d = cnt_q + 32'd1;
                end
            end
        endcase
    end

    always_ff @(posedge clk or posedge aclr) begin
        if (aclr) begin
            state_q      <= IDLE;
            steps_q      <= '0;
            period_q     <= '0;
            per_q        <= '0;
            cnt_q        <= '0;
            remain_q     <= '0;
            step_q       <= 1'b0;
            dir_q        <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            aborted_q    <= 1'b0;
            abort_pend_q <= 1'b0;
        end else if (sclr) begin
            state_q      <= IDLE;
            steps_q      <= '0;
            period_q     <= '0;
            per_q        <= '0;
            cnt_q        <= '0;
            remain_q     <= '0;
            step_q       <= 1'b0;
            dir_q        <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            aborted_q    <= 1'b0;
            abort_pend_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            steps_q      <= steps_d;
            period_q     <= period_d;
            per_q        <= per_d;
            cnt_q        <= cnt_d;
            remain_q     <= remain_d;
            step_q       <= step_d;
            dir_q        <= dir_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            aborted_q    <= aborted_d;
            abort_pend_q <= abort_pend_d;
        end
    end

    assign bus.step    = step_q;
    assign bus.dir     = dir_q;
    assign bus.busy    = busy_q;
    assign bus.done    = done_q;
    assign bus.aborted = aborted_q;
    assign bus.remain  = remain_q;

endmodule

// File: tb/tb_step_dir_gen.sv
// Directed bench for step_dir_gen: moves are captured cycle by cycle after
// start (index k = k cycles after the start cycle) and checked against hand timing.
module tb_step_dir_gen;

    logic clk = 1'b0;
    logic aclr;
    logic sclr;
    int   errors = 0;
    int   checks = 0;

    logic        cs   [0:199];
    logic        cb   [0:199];
    logic        cd   [0:199];
    logic        ca   [0:199];
    logic        cdir [0:199];
    logic [31:0] cr   [0:199];

    step_dir_gen_if bus ();

    step_dir_gen #(.PULSE_W(8), .DIR_SETUP(8)) dut (
        .clk  (clk),
        .aclr (aclr),
        .sclr (sclr),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [1:0] a, input logic [15:0] d);
        bus.addr = a; bus.be = 2'b11; bus.wrdata = d; bus.write = 1'b1;
        tick();
        bus.write = 1'b0;
    endtask

    task automatic drive_wr(input int k, input int wr_at, input logic [1:0] a, input logic [15:0] d);
        bus.write  = (k == wr_at);
        bus.addr   = a;
        bus.be     = 2'b11;
        bus.wrdata = d;
    endtask

    // Pulses start in the current cycle and records n following cycles.
    task automatic move(input int n, input int abort_at, input int wr_at,
                        input logic [1:0] wa, input logic [15:0] wd, input int restart_at);
        cs[0] = bus.step;
        bus.start = 1'b1;
        drive_wr(0, wr_at, wa, wd);
        for (int k = 1; k <= n; k++) begin
            tick();
            bus.start = (k == restart_at);
            bus.abort = (k == abort_at);
            drive_wr(k, wr_at, wa, wd);
            cs[k] = bus.step; cb[k] = bus.busy; cd[k] = bus.done;
            ca[k] = bus.aborted; cdir[k] = bus.dir; cr[k] = bus.remain;
        end
        bus.start = 1'b0; bus.abort = 1'b0; bus.write = 1'b0;
    endtask

    function automatic int rises(input int n);
        int c = 0;
        for (int k = 1; k <= n; k++) if (cs[k] && !cs[k-1]) c++;
        return c;
    endfunction

    function automatic int highs(input int n);
        int c = 0;
        for (int k = 1; k <= n; k++) if (cs[k]) c++;
        return c;
    endfunction

    function automatic int dones(input int n);
        int c = 0;
        for (int k = 1; k <= n; k++) if (cd[k]) c++;
        return c;
    endfunction

    function automatic int busies(input int n);
        int c = 0;
        for (int k = 1; k <= n; k++) if (cb[k]) c++;
        return c;
    endfunction

    initial begin
        int idle_bad;
        aclr = 1'b1; sclr = 1'b0;
        bus.addr = 2'd0; bus.be = 2'b00; bus.wrdata = 16'd0;
        bus.write = 1'b0; bus.start = 1'b0; bus.abort = 1'b0;
        repeat (3) tick();
        aclr = 1'b0;
        tick();

        chk("rst_step",    {31'd0, bus.step},    32'd0);
        chk("rst_dir",     {31'd0, bus.dir},     32'd0);
        chk("rst_busy",    {31'd0, bus.busy},    32'd0);
        chk("rst_done",    {31'd0, bus.done},    32'd0);
        chk("rst_aborted", {31'd0, bus.aborted}, 32'd0);
        chk("rst_remain",  bus.remain,           32'd0);

        // steps=3, period=20
        wr(2'd0, 16'd3); wr(2'd1, 16'd0); wr(2'd2, 16'd20); wr(2'd3, 16'd0);
        move(75, -1, -1, 2'd0, 16'd0, -1);
        chk("m1_dir",      {31'd0, cdir[1]}, 32'd0);
        chk("m1_busy1",    {31'd0, cb[1]},   32'd1);
        chk("m1_s8",       {31'd0, cs[8]},   32'd0);
        chk("m1_s9",       {31'd0, cs[9]},   32'd1);
        chk("m1_s16",      {31'd0, cs[16]},  32'd1);
        chk("m1_s17",      {31'd0, cs[17]},  32'd0);
        chk("m1_s28",      {31'd0, cs[28]},  32'd0);
        chk("m1_s29",      {31'd0, cs[29]},  32'd1);
        chk("m1_s49",      {31'd0, cs[49]},  32'd1);
        chk("m1_r8",       cr[8],  32'd3);
        chk("m1_r9",       cr[9],  32'd2);
        chk("m1_r29",      cr[29], 32'd1);
        chk("m1_r49",      cr[49], 32'd0);
        chk("m1_d68",      {31'd0, cd[68]},  32'd0);
        chk("m1_d69",      {31'd0, cd[69]},  32'd1);
        chk("m1_d70",      {31'd0, cd[70]},  32'd0);
        chk("m1_b68",      {31'd0, cb[68]},  32'd1);
        chk("m1_b69",      {31'd0, cb[69]},  32'd0);
        chk("m1_rises",    32'(rises(75)), 32'd3);
        chk("m1_highs",    32'(highs(75)), 32'd24);
        chk("m1_dones",    32'(dones(75)), 32'd1);

        // steps=-2, period=5 -> clamped to 16
        wr(2'd0, 16'hFFFE); wr(2'd1, 16'hFFFF); wr(2'd2, 16'd5);
        move(50, -1, -1, 2'd0, 16'd0, -1);
        chk("m2_dir",      {31'd0, cdir[1]}, 32'd1);
        chk("m2_r1",       cr[1], 32'd2);
        chk("m2_s9",       {31'd0, cs[9]},  32'd1);
        chk("m2_s16",      {31'd0, cs[16]}, 32'd1);
        chk("m2_s17",      {31'd0, cs[17]}, 32'd0);
        chk("m2_s24",      {31'd0, cs[24]}, 32'd0);
        chk("m2_s25",      {31'd0, cs[25]}, 32'd1);
        chk("m2_d40",      {31'd0, cd[40]}, 32'd0);
        chk("m2_d41",      {31'd0, cd[41]}, 32'd1);
        chk("m2_ab41",     {31'd0, ca[41]}, 32'd0);
        chk("m2_dir41",    {31'd0, cdir[41]}, 32'd1);
        chk("m2_rises",    32'(rises(50)), 32'd2);

        // steps=0
        wr(2'd0, 16'd0); wr(2'd1, 16'd0);
        move(5, -1, -1, 2'd0, 16'd0, -1);
        chk("m3_d1",       {31'd0, cd[1]}, 32'd1);
        chk("m3_dones",    32'(dones(5)),  32'd1);
        chk("m3_busy",     32'(busies(5)), 32'd0);
        chk("m3_highs",    32'(highs(5)),  32'd0);

        // steps=10, period=30, abort 3 cycles after 2nd rise (rise at 39)
        wr(2'd0, 16'd10); wr(2'd2, 16'd30);
        move(60, 42, -1, 2'd0, 16'd0, -1);
        chk("m4_s39",      {31'd0, cs[39]}, 32'd1);
        chk("m4_s46",      {31'd0, cs[46]}, 32'd1);
        chk("m4_s47",      {31'd0, cs[47]}, 32'd0);
        chk("m4_b46",      {31'd0, cb[46]}, 32'd1);
        chk("m4_d47",      {31'd0, cd[47]}, 32'd1);
        chk("m4_ab47",     {31'd0, ca[47]}, 32'd1);
        chk("m4_b47",      {31'd0, cb[47]}, 32'd0);
        chk("m4_r47",      cr[47], 32'd8);
        chk("m4_d48",      {31'd0, cd[48]}, 32'd0);
        chk("m4_rises",    32'(rises(60)), 32'd2);
        chk("m4_highs",    32'(highs(60)), 32'd16);
        chk("m4_ab60",     {31'd0, ca[60]}, 32'd1);

        // next move clears aborted; steps=1, period=30
        wr(2'd0, 16'd1);
        move(42, -1, -1, 2'd0, 16'd0, -1);
        chk("m5_ab1",      {31'd0, ca[1]},  32'd0);
        chk("m5_d39",      {31'd0, cd[39]}, 32'd1);
        chk("m5_rises",    32'(rises(42)), 32'd1);

        // busy write ignored, restart ignored; steps=2, period=16
        wr(2'd0, 16'd2); wr(2'd2, 16'd16);
        move(45, -1, 12, 2'd2, 16'd40, 20);
        chk("m6_s25",      {31'd0, cs[25]}, 32'd1);
        chk("m6_d41",      {31'd0, cd[41]}, 32'd1);
        chk("m6_rises",    32'(rises(45)), 32'd2);
        chk("m6_dones",    32'(dones(45)), 32'd1);

        // start+write collision: move uses period 16, register becomes 24
        move(45, -1, 0, 2'd2, 16'd24, -1);
        chk("m7_s24",      {31'd0, cs[24]}, 32'd0);
        chk("m7_s25",      {31'd0, cs[25]}, 32'd1);
        chk("m7_d41",      {31'd0, cd[41]}, 32'd1);
        chk("m7_rises",    32'(rises(45)), 32'd2);

        move(60, -1, -1, 2'd0, 16'd0, -1);
        chk("m8_s25",      {31'd0, cs[25]}, 32'd0);
        chk("m8_s33",      {31'd0, cs[33]}, 32'd1);
        chk("m8_d57",      {31'd0, cd[57]}, 32'd1);
        chk("m8_rises",    32'(rises(60)), 32'd2);

        // aclr mid-HIGH; steps=3, period=20
        wr(2'd0, 16'd3); wr(2'd2, 16'd20);
        move(12, -1, -1, 2'd0, 16'd0, -1);
        chk("m9_pre_step", {31'd0, bus.step}, 32'd1);
        #2 aclr = 1'b1;
        #1;
        chk("m9_aclr_step",   {31'd0, bus.step}, 32'd0);
        chk("m9_aclr_busy",   {31'd0, bus.busy}, 32'd0);
        chk("m9_aclr_remain", bus.remain,        32'd0);
        tick(); tick();
        aclr = 1'b0;
        idle_bad = 0;
        for (int k = 0; k < 30; k++) begin
            tick();
            if (bus.step || bus.busy) idle_bad++;
        end
        chk("m9_idle_after", 32'(idle_bad), 32'd0);

        // sclr mid-move clears state and registers
        wr(2'd0, 16'd3); wr(2'd2, 16'd20);
        move(12, -1, -1, 2'd0, 16'd0, -1);
        sclr = 1'b1;
        tick();
        sclr = 1'b0;
        chk("m10_step",    {31'd0, bus.step}, 32'd0);
        chk("m10_busy",    {31'd0, bus.busy}, 32'd0);
        chk("m10_remain",  bus.remain,        32'd0);
        move(3, -1, -1, 2'd0, 16'd0, -1);
        chk("m10_d1",      {31'd0, cd[1]}, 32'd1);
        chk("m10_b1",      {31'd0, cb[1]}, 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
